// File: rtl/softmax_sequencer_if.sv
// rtl/softmax_sequencer_if.sv - row-load handshake, PE operand/result bus and result stream bundle
//
// Purpose: groups the handshake and bus signals of softmax_sequencer.
// Ports (modport master = sequencer side, slave = environment/PE side):
//   in_valid, in_data, in_ready       row-element load handshake
//   op_code, input_up, vertical_bus   operation and operands issued to the PE
//   pe_result                         PE output_down, valid one cycle after issue
//   result_valid, result_data         normalized output stream (no backpressure)

interface softmax_sequencer_if #(
  parameter int BITWIDTH = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic [2:0]          op_code;
  logic [BITWIDTH-1:0] input_up;
  logic [BITWIDTH-1:0] vertical_bus;
  logic [BITWIDTH-1:0] pe_result;
  logic                result_valid;
  logic [BITWIDTH-1:0] result_data;

  modport master (
    input  in_valid, in_data, pe_result,
    output in_ready, op_code, input_up, vertical_bus, result_valid, result_data
  );

  modport slave (
    output in_valid, in_data, pe_result,
    input  in_ready, op_code, input_up, vertical_bus, result_valid, result_data
  );
endinterface

// File: rtl/softmax_sequencer.sv
// rtl/softmax_sequencer.sv - sequences one softmax row through a PE: load, max, exp, sum, divide
//
// Purpose: buffers ROW_LEN elements, then streams them to the PE in four passes
// (max, exp with in-place writeback, sum, divide) and forwards the divide
// results as the output stream.
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   start  begin one row (sampled only in IDLE)
//   busy   state is not IDLE
//   done   one-cycle completion pulse
//   bus    softmax_sequencer_if.master (load handshake, PE bus, result stream)

module softmax_sequencer #(
  parameter int BITWIDTH = 16,
  parameter int ROW_LEN  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  softmax_sequencer_if.master        bus
);

  localparam int IW = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(ROW_LEN - 1);

  localparam logic [2:0] OP_MAX = 3'b000;
  localparam logic [2:0] OP_EXP = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  typedef enum logic [3:0] {
    IDLE, LOAD, MAX, MAX_DR, EXP, EXP_DR, SUM, SUM_DR, DIV, DIV_DR, DONE
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_next;
  logic                iss_v;
  logic [IW-1:0]       iss_idx;
  logic [BITWIDTH-1:0] max_reg;
  logic [BITWIDTH-1:0] sum_reg;
  logic [2:0]          op_code_q;
  logic [BITWIDTH-1:0] input_up_q;
  logic                in_ready_q;
  logic                result_valid;
  logic [BITWIDTH-1:0] row_buf [ROW_LEN];

  assign idx_next = idx + IW'(1);

  function automatic state_t drain_of(input state_t s);
    case (s)
      MAX:     return MAX_DR;
      EXP:     return EXP_DR;
      SUM:     return SUM_DR;
      default: return DIV_DR;
    endcase
  endfunction

  // Outputs are registered with the value they must show in the next state,
  // so every transition also loads the first operand of the next pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      iss_v      <= 1'b0;
      iss_idx    <= '0;
      max_reg    <= '0;
      sum_reg    <= '0;
      op_code_q  <= OP_MAX;
      input_up_q <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      iss_v <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            idx        <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.in_valid && in_ready_q) begin
            if (idx == LAST) begin
              // buf[0] was written on an earlier accept (ROW_LEN >= 2)
              idx        <= '0;
              state      <= MAX;
              in_ready_q <= 1'b0;
              op_code_q  <= OP_MAX;
              input_up_q <= row_buf[0];
            end else begin
              idx <= idx_next;
            end
          end
        end
        MAX, EXP, SUM, DIV: begin
          iss_v   <= 1'b1;
          iss_idx <= idx;
          if (idx == LAST) begin
            // input_up holds buf[ROW_LEN-1] through the drain cycle
            idx   <= '0;
            state <= drain_of(state);
          end else begin
            idx        <= idx_next;
            input_up_q <= row_buf[idx_next];
          end
        end
        MAX_DR: begin
          max_reg    <= bus.pe_result;
          op_code_q  <= OP_EXP;
          input_up_q <= row_buf[0];
          state      <= EXP;
        end
        EXP_DR: begin
          // buf[0] was rewritten early in EXP, so SUM reads the exp values
          op_code_q  <= OP_ADD;
          input_up_q <= row_buf[0];
          state      <= SUM;
        end
        SUM_DR: begin
          sum_reg    <= bus.pe_result;
          op_code_q  <= OP_DIV;
          input_up_q <= row_buf[0];
          state      <= DIV;
        end
        DIV_DR: begin
          op_code_q  <= OP_MAX;
          input_up_q <= '0;
          done       <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Element storage: loaded during LOAD, overwritten in place by exp results.
  always_ff @(posedge clk) begin
    if (state == LOAD && bus.in_valid && in_ready_q) begin
      row_buf[idx] <= bus.in_data;
    end else if ((state == EXP || state == EXP_DR) && iss_v) begin
      row_buf[iss_idx] <= bus.pe_result;
    end
  end

  // The divide result is forwarded in the cycle the PE presents it.
  assign result_valid     = iss_v && (state == DIV || state == DIV_DR);
  assign bus.result_valid = result_valid;
  assign bus.result_data  = result_valid ? bus.pe_result : '0;
  assign bus.vertical_bus = (state == DIV || state == DIV_DR) ? sum_reg : max_reg;
  assign bus.in_ready     = in_ready_q;
  assign bus.op_code      = op_code_q;
  assign bus.input_up     = input_up_q;

endmodule

// File: tb/tb_softmax_sequencer.sv
// tb/tb_softmax_sequencer.sv - directed self-checking bench for softmax_sequencer

module tb_softmax_sequencer;
  localparam int BW = 16;
  localparam int N  = 4;
  localparam int P  = N + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  softmax_sequencer_if #(.BITWIDTH(BW)) ifc ();

  softmax_sequencer #(.BITWIDTH(BW), .ROW_LEN(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (ifc.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // PE stub: max pass returns 0x0042, add pass 0x0100, otherwise input_up+1.
  always @(posedge clk or posedge reset) begin
    if (reset) ifc.pe_result <= '0;
    else begin
      case (ifc.op_code)
        3'b000:  ifc.pe_result <= 16'h0042;
        3'b010:  ifc.pe_result <= 16'h0100;
        default: ifc.pe_result <= ifc.input_up + 16'd1;
      endcase
    end
  end

  // Model: t counts cycles from the first MAX cycle (t=1). Each of the four
  // passes spans ROW_LEN+1 cycles; the done pulse falls on t = 4*(ROW_LEN+1)+1.
  logic [BW-1:0] row [N];
  logic [BW-1:0] prev_max = '0;
  logic [BW-1:0] vb6 = '0;
  logic [BW-1:0] vb16 = '0;
  logic [BW-1:0] beats [$];
  int acc = 0;
  int mt = 0;
  int done_total = 0;
  int done_t = 0;

  task automatic check_cycle(input int t);
    int p, j;
    logic [BW-1:0] src, exp_vb, exp_rd;
    logic exp_rv;
    if (t <= 4 * P) begin
      p = (t - 1) / P;
      j = (t - 1) % P;
      src = (j < N) ? row[j] : row[N-1];
      if (p >= 2) src = src + 16'd1;
      exp_vb = (p == 0) ? prev_max : (p == 3) ? 16'h0100 : 16'h0042;
      exp_rv = (p == 3) && (j >= 1);
      exp_rd = '0;
      if (exp_rv) exp_rd = row[j-1] + 16'd2;
      chk("op_code", ifc.op_code, 3'(p));
      chk("input_up", ifc.input_up, src);
      chk("vertical_bus", ifc.vertical_bus, exp_vb);
      chk("result_valid", ifc.result_valid, exp_rv);
      chk("result_data", ifc.result_data, exp_rd);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("in_ready_run", ifc.in_ready, 0);
      if (t == 6)  vb6  = ifc.vertical_bus;
      if (t == 16) vb16 = ifc.vertical_bus;
    end else if (t == 4 * P + 1) begin
      chk("done_pulse", done, 1);
      chk("busy_done", busy, 1);
      chk("op_code_done", ifc.op_code, 0);
      chk("result_valid_done", ifc.result_valid, 0);
      chk("vertical_bus_done", ifc.vertical_bus, 16'h0042);
    end else begin
      chk("busy_idle", busy, 0);
      chk("done_after", done, 0);
      prev_max = 16'h0042;
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mt = 0;
      acc = 0;
      prev_max = '0;
    end else begin
      if (done) begin
        done_total++;
        done_t = mt;
      end
      if (ifc.result_valid) beats.push_back(ifc.result_data);
      if (mt == 0) begin
        chk("idle_result_valid", ifc.result_valid, 0);
        chk("idle_done", done, 0);
      end else begin
        check_cycle(mt);
        mt = (mt == 4 * P + 2) ? 0 : mt + 1;
      end
      if (ifc.in_valid && ifc.in_ready) begin
        row[acc] = ifc.in_data;
        acc++;
        if (acc == N) begin
          acc = 0;
          mt = 1;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, ifc.in_ready, 0);
    chk({tag, "_op_code"}, ifc.op_code, 0);
    chk({tag, "_input_up"}, ifc.input_up, 0);
    chk({tag, "_vertical_bus"}, ifc.vertical_bus, 0);
    chk({tag, "_result_valid"}, ifc.result_valid, 0);
    chk({tag, "_result_data"}, ifc.result_data, 0);
  endtask

  task automatic load_row(input logic [BW-1:0] d [N], input bit gaps);
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = d[i];
      chk("in_ready_load", ifc.in_ready, 1);
      @(posedge clk) #1;
      ifc.in_valid = 1'b0;
      if (gaps && i < N - 1) @(posedge clk) #1;
    end
    chk("in_ready_after_last", ifc.in_ready, 0);
    chk("first_op_code", ifc.op_code, 0);
    chk("first_input_up", ifc.input_up, d[0]);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk) #1;
      if (done) seen = 1'b1;
    end
    chk(name, seen, 1);
    @(posedge clk) #1;
  endtask

  logic [BW-1:0] ra [N] = '{16'd1, 16'd2, 16'd3, 16'd4};
  logic [BW-1:0] rb [N] = '{16'h00ff, 16'h1234, 16'hfffe, 16'h7fff};
  logic [BW-1:0] rd [N] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
  logic [BW-1:0] rc [N] = '{16'h0aaa, 16'h0555, 16'h0001, 16'h8000};
  logic [BW-1:0] ea [N] = '{16'd3, 16'd4, 16'd5, 16'd6};

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b0;
    @(posedge clk) #1;

    // Row A: 1..4 with gaps; stub gives max 0x42, sum 0x100, stream 3..6
    beats.delete();
    load_row(ra, 1'b1);
    wait_done("done_row_a");
    chk("beats_a_count", beats.size(), N);
    for (int i = 0; i < N; i++) chk("beat_a", (i < beats.size()) ? beats[i] : 16'hdead, ea[i]);
    chk("done_cycle_a", done_t, 21);
    chk("vb_exp_a", vb6, 16'h0042);
    chk("vb_div_a", vb16, 16'h0100);

    // Row B: back-to-back load, start pulsed during EXP must be ignored
    load_row(rb, 1'b0);
    repeat (6) @(posedge clk) #1;
    chk("in_exp_pass", ifc.op_code, 3'b001);
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    wait_done("done_row_b");
    repeat (5) @(posedge clk) #1;
    chk("done_total_b", done_total, 2);

    // Reset asserted in LOAD
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = rd[i];
      @(posedge clk) #1;
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_load");
    ifc.in_valid = 1'b0;
    @(posedge clk) #1;
    reset = 1'b0;
    repeat (10) @(posedge clk) #1;

    // Reset asserted in DIV
    load_row(rd, 1'b0);
    begin
      bit seen_div = 1'b0;
      for (int k = 0; k < 40 && !seen_div; k++) begin
        if (ifc.op_code == 3'b011) seen_div = 1'b1;
        else @(posedge clk) #1;
      end
      chk("reach_div", seen_div, 1);
    end
    repeat (2) @(posedge clk) #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_div");
    @(posedge clk) #1;
    reset = 1'b0;
    repeat (30) @(posedge clk) #1;
    chk("no_done_after_abort", done_total, 2);

    // Row C after abort runs normally
    load_row(rc, 1'b1);
    wait_done("done_row_c");
    repeat (3) @(posedge clk) #1;
    chk("done_total_c", done_total, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
